// File: rtl/boid_fetch_if.sv
// Bus bundle for boid_fetch: synchronous RAM read port plus the renderer
// valid/ready entry stream. master = boid_fetch, slave = RAM/renderer side.
interface boid_fetch_if #(
  parameter int ADDR_W = 12,
  parameter int IDX_W  = 6
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [9:0]        out_x;
  logic [8:0]        out_y;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output mem_addr,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output out_x,
    output out_y,
    output out_idx,
    output out_last
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  out_x,
    input  out_y,
    input  out_idx,
    input  out_last
  );

endinterface

// File: rtl/boid_fetch.sv
// Walks the boid position table in RAM once per vertical blank and streams one
// (x, y, idx) entry per boid. Define BOID_FETCH_CLAMP_EN to saturate x/y on screen.
module boid_fetch #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h100,
  parameter int                MAX_BOIDS = 64
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  boid_fetch_if.master bus,
  output logic         busy,
  output logic         frame_done,
  output logic         overrun
);

  localparam int IDX_W = (MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_RD,
    S_CNT_WAIT,
    S_ENT_RD,
    S_ENT_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_mem_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_out_valid;
  logic [9:0]        r_out_x;
  logic [8:0]        r_out_y;
  logic [IDX_W-1:0]  r_out_idx;
  logic              r_out_last;
  logic              r_overrun;

  logic              w_addr_cnt;
  logic              w_addr_ent;
  logic              w_load_cnt;
  logic              w_idx_inc;
  logic              w_load_out;
  logic              w_clr_valid;
  logic [CNT_W-1:0]  w_cnt_in;
  logic [IDX_W-1:0]  w_ent_idx;
  logic [ADDR_W-1:0] w_ent_addr;
  logic              w_last;
  logic [9:0]        w_x;
  logic [8:0]        w_y;

  // Count word is clamped as an unsigned 32-bit value so huge counts cap cleanly.
  assign w_cnt_in   = (bus.mem_rdata > 32'(MAX_BOIDS)) ? CNT_W'(MAX_BOIDS)
                                                       : bus.mem_rdata[CNT_W-1:0];
  assign w_ent_idx  = w_load_cnt ? '0 : r_idx + 1'b1;
  assign w_ent_addr = BASE_ADDR + ADDR_W'(1) + ADDR_W'(w_ent_idx);
  assign w_last     = ({1'b0, r_idx} == (r_cnt - CNT_W'(1)));

`ifdef BOID_FETCH_CLAMP_EN
  assign w_x = (bus.mem_rdata[25:16] > 10'd639) ? 10'd639 : bus.mem_rdata[25:16];
  assign w_y = (bus.mem_rdata[8:0]   > 9'd479)  ? 9'd479  : bus.mem_rdata[8:0];
`else
  assign w_x = bus.mem_rdata[25:16];
  assign w_y = bus.mem_rdata[8:0];
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    w_next      = r_state;
    w_addr_cnt  = 1'b0;
    w_addr_ent  = 1'b0;
    w_load_cnt  = 1'b0;
    w_idx_inc   = 1'b0;
    w_load_out  = 1'b0;
    w_clr_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next     = S_CNT_RD;
          w_addr_cnt = 1'b1;
        end
      end
      S_CNT_RD:   w_next = S_CNT_WAIT;
      S_CNT_WAIT: begin
        w_load_cnt = 1'b1;
        if (w_cnt_in == '0) begin
          w_next = S_DONE;
        end else begin
          w_next     = S_ENT_RD;
          w_addr_ent = 1'b1;
        end
      end
      S_ENT_RD:   w_next = S_ENT_WAIT;
      S_ENT_WAIT: begin
        w_load_out = 1'b1;
        w_next     = S_HOLD;
      end
      S_HOLD: begin
        if (r_out_valid && bus.out_ready) begin
          w_clr_valid = 1'b1;
          if (r_out_last) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_ENT_RD;
            w_idx_inc  = 1'b1;
            w_addr_ent = 1'b1;
          end
        end
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // The read address is registered on entry to each read state, so the RAM sees
  // it during that state and its data is ready in the following wait state.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mem_addr  <= BASE_ADDR;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_addr_cnt)      r_mem_addr <= BASE_ADDR;
      else if (w_addr_ent) r_mem_addr <= w_ent_addr;

      if (w_load_cnt) begin
        r_cnt <= w_cnt_in;
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end

      if (w_load_out) begin
        r_out_valid <= 1'b1;
        r_out_x     <= w_x;
        r_out_y     <= w_y;
        r_out_idx   <= r_idx;
        r_out_last  <= w_last;
      end else if (w_clr_valid) begin
        r_out_valid <= 1'b0;
      end

      if (start && (r_state != S_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_x     = r_out_x;
  assign bus.out_y     = r_out_y;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_last  = r_out_last;

  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_boid_fetch.sv
// Scoreboard bench for boid_fetch: RAM model, expected entries queued when the
// table is loaded, popped and compared on every accepted beat.
module tb_boid_fetch;

  localparam int          ADDR_W = 12;
  localparam int          IDX_W  = 6;
  localparam logic [11:0] BASE   = 12'h100;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [5:0] idx;
    logic       last;
  } exp_t;

  logic clock = 1'b0;
  logic resetn;
  logic start;
  logic busy, frame_done, overrun;

  boid_fetch_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

  boid_fetch #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_BOIDS(64)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #10 clock = ~clock;

  logic [31:0] mem [0:4095];
  always @(posedge clock) bus.mem_rdata <= mem[bus.mem_addr];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t q[$];

  int   beats, busy_cnt, stall_cnt, fd_cnt, fd_cyc, hs_cyc, first_valid_cyc, samp_cyc;
  logic seen_valid, prev_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_x(input logic [9:0] raw);
`ifdef BOID_FETCH_CLAMP_EN
    return (raw > 10'd639) ? 10'd639 : raw;
`else
    return raw;
`endif
  endfunction

  function automatic logic [8:0] exp_y(input logic [8:0] raw);
`ifdef BOID_FETCH_CLAMP_EN
    return (raw > 9'd479) ? 9'd479 : raw;
`else
    return raw;
`endif
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compares every valid cycle (including stalls) with the queue head.
  always @(negedge clock) begin
    if (resetn) begin
      if (busy) busy_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (prev_stall) check("stall_valid_held", 32'(bus.out_valid), 1);
      if (bus.out_valid) begin
        if (!seen_valid) begin
          seen_valid      = 1'b1;
          first_valid_cyc = cyc;
        end
        if (q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          check("beat_x",    32'(bus.out_x),    32'(q[0].x));
          check("beat_y",    32'(bus.out_y),    32'(q[0].y));
          check("beat_idx",  32'(bus.out_idx),  32'(q[0].idx));
          check("beat_last", 32'(bus.out_last), 32'(q[0].last));
        end
        if (bus.out_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          beats++;
          hs_cyc = cyc;
        end else begin
          stall_cnt++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic put_entry(input int i, input logic [9:0] x, input logic [8:0] y, input int n);
    exp_t e;
    logic [31:0] junk;
    junk = $urandom;
    mem[BASE + 12'(1 + i)] = {junk[31:26], x, junk[15:9], y};
    if (i < n) begin
      e.x    = exp_x(x);
      e.y    = exp_y(y);
      e.idx  = 6'(i);
      e.last = (i == n - 1);
      q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    samp_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int fd0, k;
    fd0 = fd_cnt;
    k   = 0;
    while (fd_cnt == fd0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (fd_cnt == fd0) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic begin_frame();
    beats      = 0;
    busy_cnt   = 0;
    stall_cnt  = 0;
    seen_valid = 1'b0;
  endtask

  task automatic end_frame(input string tag, input int exp_beats);
    repeat (2) @(posedge clock);
    #1;
    check({tag, "_beats"},   beats, exp_beats);
    check({tag, "_q_empty"}, q.size(), 0);
    check({tag, "_busy_lo"}, 32'(busy), 0);
  endtask

  initial begin
    int fd0;
    int k;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    resetn         = 1'b0;
    start          = 1'b0;
    bus.out_ready  = 1'b1;
    prev_stall     = 1'b0;
    fd_cnt         = 0;
    fd_cyc         = 0;
    hs_cyc         = 0;
    begin_frame();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid",    32'(bus.out_valid),  0);
    check("rst_addr",     32'(bus.mem_addr),   32'(BASE));
    check("rst_busy",     32'(busy),           0);
    check("rst_done",     32'(frame_done),     0);
    check("rst_overrun",  32'(overrun),        0);
    check("rst_xylast",   {bus.out_x, bus.out_y, bus.out_idx, bus.out_last}, 0);
    @(negedge clock) resetn = 1'b1;

    // Three entries, ready held high
    mem[BASE] = 32'd3;
    put_entry(0, 10'd10,  9'd20,  3);
    put_entry(1, 10'd639, 9'd479, 3);
    put_entry(2, 10'd0,   9'd0,   3);
    begin_frame();
    pulse_start();
    wait_done("f3", 500);
    check("f3_first_valid_lat", first_valid_cyc - samp_cyc, 4);
    check("f3_done_after_hs",   fd_cyc - hs_cyc, 1);
    end_frame("f3", 3);
    check("f3_addr_hold", 32'(bus.mem_addr), 32'(BASE + 12'd3));

    // Zero count: no beats, done three cycles after start was raised
    mem[BASE] = 32'd0;
    begin_frame();
    pulse_start();
    wait_done("f0", 100);
    check("f0_done_lat",  fd_cyc - samp_cyc + 1, 3);
    check("f0_busy_cycles", busy_cnt, 3);
    check("f0_no_valid",  32'(seen_valid), 0);
    end_frame("f0", 0);

    // Count 1000 clamps to 64 beats; entry 64 must never be fetched
    mem[BASE] = 32'd1000;
    for (int i = 0; i < 65; i++) put_entry(i, 10'($urandom), 9'($urandom), 64);
    begin_frame();
    pulse_start();
    wait_done("f64", 2000);
    end_frame("f64", 64);

    // Backpressure: beat 1 stalled for 5 cycles
    mem[BASE] = 32'd4;
    for (int i = 0; i < 4; i++) put_entry(i, 10'($urandom), 9'($urandom), 4);
    begin_frame();
    pulse_start();
    k = 0;
    while (!(bus.out_valid && bus.out_idx == 6'd0) && k < 50) begin
      @(negedge clock);
      k++;
    end
    @(posedge clock); #1 bus.out_ready = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(negedge clock);
      k++;
    end
    repeat (4) @(negedge clock);
    @(posedge clock); #1 bus.out_ready = 1'b1;
    wait_done("bp", 500);
    check("bp_stall_cycles", stall_cnt, 5);
    end_frame("bp", 4);

    // Start re-pulsed mid-walk
    check("ovr_pre", 32'(overrun), 0);
    mem[BASE] = 32'd3;
    for (int i = 0; i < 3; i++) put_entry(i, 10'($urandom), 9'($urandom), 3);
    begin_frame();
    pulse_start();
    repeat (6) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done("ovr", 500);
    check("ovr_set", 32'(overrun), 1);
    end_frame("ovr", 3);
    repeat (5) @(posedge clock);
    #1 check("ovr_sticky", 32'(overrun), 1);

    // Asynchronous reset mid-walk
    mem[BASE] = 32'd5;
    for (int i = 0; i < 5; i++) put_entry(i, 10'($urandom), 9'($urandom), 5);
    begin_frame();
    pulse_start();
    k = 0;
    while (beats < 2 && k < 100) begin
      @(negedge clock);
      k++;
    end
    @(posedge clock); #3 resetn = 1'b0;
    #1;
    check("arst_valid",   32'(bus.out_valid), 0);
    check("arst_busy",    32'(busy),          0);
    check("arst_overrun", 32'(overrun),       0);
    check("arst_addr",    32'(bus.mem_addr),  32'(BASE));
    check("arst_x",       32'(bus.out_x),     0);
    q.delete();
    fd0 = fd_cnt;
    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    seen_valid = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check("arst_no_done",  fd_cnt, fd0);
    check("arst_no_valid", 32'(seen_valid), 0);

    // Out-of-range fields: clamped or raw depending on build
    mem[BASE] = 32'd1;
    put_entry(0, 10'd1023, 9'd511, 1);
    begin_frame();
    pulse_start();
    wait_done("clamp", 100);
    end_frame("clamp", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/boid_fetch.md
Name: boid_fetch

Overview:
- Bus reader that walks the boid position table written by the processor into data RAM and streams one entry per boid to the VGA sprite renderer over a valid/ready handshake.
- Sits between a dedicated synchronous read port of the processor RAM and the renderer. The processor side is the writer; this block is the reader.
- Runs once per frame when triggered by a vertical-blank pulse.

Parameters:
- ADDR_W, 12, RAM word-address width.
- BASE_ADDR, 12'h100, address of the count word. Boid i is at BASE_ADDR+1+i.
- MAX_BOIDS, 64, upper clamp on the count word. Sets the out_idx width as clog2(MAX_BOIDS).

Ports:
- clock  in  1  system clock (50 MHz domain).
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse at start of vertical blank.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rdata  in  32  RAM read data, valid 1 cycle after mem_addr.
- out_valid  out  1  entry valid.
- out_ready  in  1  renderer accepts the entry.
- out_x  out  10  boid x, taken from mem_rdata[25:16].
- out_y  out  9  boid y, taken from mem_rdata[8:0].
- out_idx  out  clog2(MAX_BOIDS)  boid index.
- out_last  out  1  marks the final entry of the frame.
- busy  out  1  a walk is in progress.
- frame_done  out  1  one-cycle pulse when a walk completes.
- overrun  out  1  sticky flag: start arrived while busy.

Behaviour:
- Reset values:
  - all outputs 0; mem_addr = BASE_ADDR.
  - state = IDLE; internal count and index = 0.
  - Reset is asynchronous, so assertion mid-walk aborts the walk immediately. No frame_done is produced.
- FSM states: IDLE, CNT_RD, CNT_WAIT, ENT_RD, ENT_WAIT, HOLD, DONE.
- IDLE: on start, go to CNT_RD and set busy=1.
- CNT_RD: drive mem_addr=BASE_ADDR, then go to CNT_WAIT.
- CNT_WAIT: latch N = min(mem_rdata, MAX_BOIDS), compared as unsigned 32-bit.
  - If N==0, go to DONE.
  - Otherwise set idx=0 and go to ENT_RD.
- ENT_RD: drive mem_addr = BASE_ADDR+1+idx, truncated to ADDR_W (wraps modulo 2^ADDR_W). Go to ENT_WAIT.
- ENT_WAIT: register out_x, out_y, out_idx=idx and out_last=(idx==N-1). Assert out_valid and go to HOLD.
- HOLD:
  - out_x, out_y, out_idx and out_last stay stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready, drop out_valid.
  - If out_last, go to DONE; otherwise idx++ and go to ENT_RD.
  - out_ready is ignored when out_valid=0.
- DONE: pulse frame_done for one cycle, clear busy, return to IDLE.
- Latency from the start pulse:
  - first out_valid on the 4th rising edge after start is sampled, provided out_ready is held high;
  - each subsequent entry takes 3 cycles, i.e. one beat per 3 clocks.
- start during any non-IDLE state is ignored. It sets overrun=1, which clears only on reset.
- start in the same cycle as the DONE pulse is also counted as an overrun.
- The count word is read once per walk. Processor writes to the table mid-walk affect only entries not yet fetched.
- mem_addr holds its last value outside the read states.

Optional Feature:
- Macro: BOID_FETCH_CLAMP_EN.
- With the macro defined: out_x saturates to 639 when the raw field is >639, and out_y saturates to 479 when the raw field is >479, so every sprite stays on screen.
- Without the macro: raw bit fields pass through unmodified.

Test Plan:
- Count word 3 with entries x=10/y=20, x=639/y=479, x=0/y=0, out_ready held 1:
  - exactly 3 beats with idx 0,1,2;
  - out_last only on idx 2;
  - frame_done pulse 1 cycle after the last handshake;
  - busy low afterwards.
- Count word 0:
  - no out_valid;
  - frame_done asserted 3 cycles after start;
  - busy 1 for exactly those cycles.
- Count word 1000 with MAX_BOIDS=64: 64 beats, out_last at idx 63.
- Backpressure: out_ready low for 5 cycles on beat 1 -> out_valid and data held stable for all 5 cycles, no beats skipped or duplicated.
- start re-pulsed mid-walk -> walk unaffected, overrun=1 and it stays 1 after frame_done. resetn pulsed low mid-walk -> all outputs 0 asynchronously, no frame_done.
- Entry x=1023, y=511:
  - with BOID_FETCH_CLAMP_EN defined -> out_x=639, out_y=479;
  - without it -> out_x=1023, out_y=511.
